// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits. A shadow register holds the displayed hex value and
// decimal points, and a prescaler sets how long each digit stays lit.
// Segment and anode outputs are registered, and they reflect the scan index
// and shadow contents as updated by the same clock edge.
// Optional build macro: SEVEN_SEG_LZ_BLANK_EN enables leading-zero blanking.
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    en,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           presc;
    logic [PW-1:0]           presc_nxt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_nxt;
    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [4*NUM_DIGITS-1:0] sh_val_nxt;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_dp_nxt;
    logic                    tick;
    logic [3:0]              nib;
    logic                    dp_bit;
    logic                    lz;
    logic [6:0]              glyph;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    // Active-low a..g patterns for the hex digits 0..F
    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h18;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Next prescaler, scan index and shadow contents for this edge
    always_comb begin
        tick       = en && (presc == PW'(REFRESH_DIV - 1));
        presc_nxt  = presc;
        idx_nxt    = idx;
        sh_val_nxt = load ? value : sh_val;
        sh_dp_nxt  = load ? dp : sh_dp;
        if (en) begin
            presc_nxt = tick ? '0 : presc + 1'b1;
        end
        if (tick) begin
            idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Select the digit being scanned from the freshly updated shadow, so a
    // load coinciding with a tick never shows stale data
    always_comb begin
        nib    = '0;
        dp_bit = 1'b0;
        lz     = 1'b0;
        an_nxt = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx_nxt) begin
                nib       = sh_val_nxt[4*k +: 4];
                dp_bit    = sh_dp_nxt[k];
                an_nxt[k] = 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
                lz        = (k != 0) && ((sh_val_nxt >> (4*k)) == '0);
`endif
            end
        end
    end

    // Build the full segment byte; blank everything while disabled
    always_comb begin
        glyph   = lz ? 7'h7F : hex_glyph(nib);
        seg_nxt = en ? {~dp_bit, glyph} : 8'hFF;
    end

    // Prescaler and scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc_nxt;
            idx   <= idx_nxt;
        end
    end

    // Shadow register for the displayed value and decimal points
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_val <= '0;
            sh_dp  <= '0;
        end else begin
            sh_val <= sh_val_nxt;
            sh_dp  <= sh_dp_nxt;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            an  <= en ? an_nxt : '1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: checks seven_seg_scan against a behavioural model that
// derives the scanned digit from the count of enabled clock edges since reset.
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int RD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4*ND-1:0] value = '0;
    logic [ND-1:0]   dp = '0;
    logic            load = 1'b0;
    logic            en = 1'b1;
    logic [7:0]      seg;
    logic [ND-1:0]   an;

    int n_asserts = 0;
    int n_fail    = 0;
    bit checking  = 1'b0;

    // model state
    int              n_en = 0;
    logic [4*ND-1:0] m_val = '0;
    logic [ND-1:0]   m_dp = '0;
    logic [7:0]      exp_seg = 8'hFF;
    logic [ND-1:0]   exp_an = '1;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .dp    (dp),
        .load  (load),
        .en    (en),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: digit shown = (enabled edges since reset / RD) mod ND
    initial forever begin
        int d;
        bit blank_lz;
        logic [7:0] s;
        @(posedge clk or posedge rst);
        if (rst) begin
            n_en = 0; m_val = '0; m_dp = '0;
            exp_an = '1; exp_seg = 8'hFF;
        end else begin
            if (load) begin
                m_val = value;
                m_dp  = dp;
            end
            if (en) begin
                n_en++;
                d = (n_en / RD) % ND;
                blank_lz = 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
                blank_lz = (d > 0) && ((m_val >> (4*d)) == 0);
`endif
                s = seg_tbl[(m_val >> (4*d)) & 4'hF];
                if (blank_lz) s = 8'hFF;
                s[7] = ~m_dp[d];
                exp_seg = s;
                exp_an = '1;
                exp_an[d] = 1'b0;
            end else begin
                exp_an = '1;
                exp_seg = 8'hFF;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        if (checking) begin
            chk("model_an", an, exp_an);
            chk("model_seg", seg, exp_seg);
        end
    end

    // Assert reset shortly after an edge, check immediate blanking, release before next edge
    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        #2;
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 8'hFF);
        edges(1);
        rst = 1'b0;
    endtask

    logic [3:0] an_lit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] seg27  [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic [7:0] seg29  [4] = '{8'h92, 8'hFF, 8'h7F, 8'hFF};
`else
    logic [7:0] seg29  [4] = '{8'h92, 8'hC0, 8'h40, 8'hC0};
`endif

    initial begin
        logic [4*ND-1:0] mask;
        edges(2);
        chk("init_an", an, 4'b1111);
        rst = 1'b0;
        checking = 1'b1;

        // reset release, no load: digit 0 shows 0, advances on the 4th edge
        do_reset();
        en = 1'b1;
        edges(1);
        chk("first_an", an, 4'b1110);
        chk("first_seg", seg, 8'hC0);
        edges(2);
        chk("dwell3_an", an, 4'b1110);
        edges(1);
        chk("adv_an", an, 4'b1101);

        // 12AF scan sequence
        do_reset();
        value = 16'h12AF; dp = '0; load = 1'b1;
        edges(1);
        load = 1'b0;
        chk("scan_an", an, an_lit[0]);
        chk("scan_seg", seg, seg27[0]);
        for (int e = 2; e <= 16; e++) begin
            edges(1);
            chk("scan_an", an, an_lit[(e / 4) % 4]);
            chk("scan_seg", seg, seg27[(e / 4) % 4]);
        end

        // leading zeros with a decimal point on digit 2
        do_reset();
        value = 16'h0005; dp = 4'b0100; load = 1'b1;
        edges(1);
        load = 1'b0;
        chk("lz_d0", seg, seg29[0]);
        edges(3);
        chk("lz_d1", seg, seg29[1]);
        edges(4);
        chk("lz_d2", seg, seg29[2]);
        edges(4);
        chk("lz_d3", seg, seg29[3]);

        // value change without load is ignored; load on tick shows new data
        do_reset();
        value = '0; dp = '0;
        edges(2);
        value = 16'h9999;
        edges(1);
        chk("noload_seg", seg, 8'hC0);
        load = 1'b1;
        edges(1);
        load = 1'b0;
        chk("ldtick_an", an, 4'b1101);
        chk("ldtick_seg", seg, 8'h98);
        edges(1);

        // en dropped mid-dwell for 10 clocks, then resumes the same digit
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk("off_an", an, 4'b1111);
            chk("off_seg", seg, 8'hFF);
        end
        en = 1'b1;
        edges(1);
        chk("resume1_an", an, 4'b1101);
        chk("resume1_seg", seg, 8'h98);
        edges(1);
        chk("resume2_an", an, 4'b1101);
        edges(1);
        chk("resume3_an", an, 4'b1011);

        // asynchronous reset pulse between edges mid-scan
        #2 rst = 1'b1;
        #1;
        chk("async_an", an, 4'b1111);
        chk("async_seg", seg, 8'hFF);
        rst = 1'b0;
        edges(1);
        chk("restart_an", an, 4'b1110);
        chk("restart_seg", seg, 8'hC0);

        // randomized traffic against the model
        repeat (3000) begin
            mask = '1 >> (4 * $urandom_range(0, ND));
            value = 16'($urandom) & mask;
            dp    = 4'($urandom);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            edges(1);
        end

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
